// File: rtl/nibble_word_assembler_pkg.sv
// Shared definitions for the nibble word assembler and its read-side selector.
// Holds the default geometry, the select width and the slot-to-bit mapping.
package nibble_word_assembler_pkg;

    localparam int NIB_W_DEF   = 4;
    localparam int NUM_NIB_DEF = 4;
    localparam int SEL_W       = $clog2(NUM_NIB_DEF);
    localparam int WORD_W_DEF  = NIB_W_DEF * NUM_NIB_DEF;

    // Fill phase of the collector: the last slot is the only one that can stall.
    typedef enum logic {
        PH_COLLECT = 1'b0,
        PH_LAST    = 1'b1
    } fill_phase_e;

    // Lowest word bit covered by a slot; shared with the read-side selector.
    function automatic int slot_offset(input int slot, input int nib_w);
        return slot * nib_w;
    endfunction

endpackage

// File: rtl/nibble_word_assembler_if.sv
// Handshake bundle of the nibble word assembler: nibble stream in, word out.
// slave is the assembler's view, master the view of the source/consumer side.
interface nibble_word_assembler_if
    import nibble_word_assembler_pkg::*;
#(
    parameter int NIB_W   = NIB_W_DEF,
    parameter int NUM_NIB = NUM_NIB_DEF
);
    localparam int WORD_W   = NIB_W * NUM_NIB;
    localparam int SEL_BITS = $clog2(NUM_NIB);

    logic [NIB_W-1:0]    nib_in;
    logic                nib_valid;
    logic                nib_ready;
    logic [SEL_BITS-1:0] sel_out;
    logic [WORD_W-1:0]   word_out;
    logic                word_valid;
    logic                word_ready;

    modport master (
        output nib_in, nib_valid, word_ready,
        input  nib_ready, sel_out, word_out, word_valid
    );

    modport slave (
        input  nib_in, nib_valid, word_ready,
        output nib_ready, sel_out, word_out, word_valid
    );

endinterface

// File: rtl/nibble_word_assembler_word_out_buffer.sv
// One-entry valid/ready output register. load captures a new word and raises
// valid, take drops valid, clr drops valid and keeps the data.
module word_out_buffer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic         take,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_out,
    output logic         valid
);

    // Hold the word until the consumer takes it; a same-cycle load refills it.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rst_n) begin
            data_out <= '0;
            valid    <= 1'b0;
        end else if (clr) begin
            valid    <= 1'b0;
        end else if (load) begin
            data_out <= data_in;
            valid    <= 1'b1;
        end else if (take) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/nibble_word_assembler.sv
// Collects a stream of nibbles into a word; slot k fills bits [k*NIB_W +: NIB_W].
// Define NIBBLE_MSB_FIRST_EN to fill the top slot first (sel_out counts down).
module nibble_word_assembler
    import nibble_word_assembler_pkg::*;
#(
    parameter int NIB_W   = NIB_W_DEF,
    parameter int NUM_NIB = NUM_NIB_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    nibble_word_assembler_if.slave bus
);

    localparam int WORD_W   = NIB_W * NUM_NIB;
    localparam int SEL_BITS = $clog2(NUM_NIB);

`ifdef NIBBLE_MSB_FIRST_EN
    localparam logic [SEL_BITS-1:0] FIRST_SLOT = SEL_BITS'(NUM_NIB - 1);
    localparam logic [SEL_BITS-1:0] LAST_SLOT  = '0;
`else
    localparam logic [SEL_BITS-1:0] FIRST_SLOT = '0;
    localparam logic [SEL_BITS-1:0] LAST_SLOT  = SEL_BITS'(NUM_NIB - 1);
`endif

    logic [SEL_BITS-1:0] cnt;
    logic [SEL_BITS-1:0] cnt_step;
    logic [WORD_W-1:0]   staging;
    logic [WORD_W-1:0]   word_next;
    fill_phase_e         phase;
    logic                accept;
    logic                load;
    logic                take;

    assign phase         = (cnt == LAST_SLOT) ? PH_LAST : PH_COLLECT;
    // Only the closing nibble waits for the output buffer to free up.
    assign bus.nib_ready = !(phase == PH_LAST && bus.word_valid && !bus.word_ready);
    assign accept        = bus.nib_valid && bus.nib_ready && !clr;
    assign load          = accept && (phase == PH_LAST);
    assign take          = bus.word_valid && bus.word_ready;
    assign bus.sel_out   = cnt;

    // Next slot index and the word formed by merging the last nibble into staging.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        word_next = staging;
        word_next[slot_offset(int'(LAST_SLOT), NIB_W) +: NIB_W] = bus.nib_in;
`ifdef NIBBLE_MSB_FIRST_EN
        cnt_step  = cnt - SEL_BITS'(1);
`else
        cnt_step  = cnt + SEL_BITS'(1);
`endif
    end

    // Slot counter and staging register; the last nibble bypasses staging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= FIRST_SLOT;
            staging <= '0;
        end else if (clr) begin
            cnt     <= FIRST_SLOT;
        end else if (accept) begin
            if (phase == PH_LAST) begin
                cnt <= FIRST_SLOT;
            end else begin
                staging[slot_offset(int'(cnt), NIB_W) +: NIB_W] <= bus.nib_in;
                cnt <= cnt_step;
            end
        end
    end

    word_out_buffer #(
        .W(WORD_W)
    ) u_word_out_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .load    (load),
        .take    (take),
        .data_in (word_next),
        .data_out(bus.word_out),
        .valid   (bus.word_valid)
    );

endmodule

// File: tb/tb_nibble_word_assembler.sv
// Self-checking bench for nibble_word_assembler. A small model tracks the slot
// count and builds expected words, pushed when the closing nibble is accepted
// and popped when the DUT transfers a word.
module tb_nibble_word_assembler;

    logic clk;
    logic rst_n;
    logic clr;

    nibble_word_assembler_if #(.NIB_W(4), .NUM_NIB(4)) bus ();

    nibble_word_assembler #(
        .NIB_W  (4),
        .NUM_NIB(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    int          m_cnt  = 0;
    logic [15:0] m_word = '0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slot filled by the k-th nibble of a word.
    function automatic int slot_of(input int k);
`ifdef NIBBLE_MSB_FIRST_EN
        return 3 - k;
`else
        return k;
`endif
    endfunction

    function automatic logic [15:0] exp_word(input logic [3:0] n0, input logic [3:0] n1,
                                             input logic [3:0] n2, input logic [3:0] n3);
        logic [15:0] w;
        w = '0;
        w[slot_of(0)*4 +: 4] = n0;
        w[slot_of(1)*4 +: 4] = n1;
        w[slot_of(2)*4 +: 4] = n2;
        w[slot_of(3)*4 +: 4] = n3;
        return w;
    endfunction

    // One clock: drive at negedge, check outputs, update model, advance to next negedge.
    task automatic cycle(input logic v, input logic [3:0] n, input logic wr, input logic c);
        logic acc;
        logic xfer;
        logic [15:0] w;
        bus.nib_valid  = v;
        bus.nib_in     = n;
        bus.word_ready = wr;
        clr            = c;
        #1;
        check("sel_out", 32'(bus.sel_out), 32'(slot_of(m_cnt)));
        check("word_valid", 32'(bus.word_valid), 32'(exp_q.size() != 0));
        check("nib_ready", 32'(bus.nib_ready), 32'(!(m_cnt == 3 && exp_q.size() != 0 && !wr)));
        acc  = v && bus.nib_ready && !c;
        xfer = bus.word_valid && wr && !c;
        if (c) begin
            exp_q.delete();
            m_cnt = 0;
        end else begin
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    check("word_valid_unexpected", 32'(bus.word_valid), 32'd0);
                end else begin
                    w = exp_q.pop_front();
                    check("word_out", 32'(bus.word_out), 32'(w));
                end
            end
            if (acc) begin
                m_word[slot_of(m_cnt)*4 +: 4] = n;
                if (m_cnt == 3) begin
                    exp_q.push_back(m_word);
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic wr);
        cycle(1'b0, 4'h0, wr, 1'b0);
    endtask

    initial begin
        rst_n          = 1'b0;
        clr            = 1'b0;
        bus.nib_valid  = 1'b0;
        bus.nib_in     = '0;
        bus.word_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state.
        check("rst_sel_out", 32'(bus.sel_out), 32'(slot_of(0)));
        check("rst_word_valid", 32'(bus.word_valid), 32'd0);
        check("rst_word_out", 32'(bus.word_out), 32'd0);
        check("rst_nib_ready", 32'(bus.nib_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic fill, consumer always ready.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b1, 1'b0);
        check("basic_word", 32'(bus.word_out), 32'(exp_word(4'h1, 4'h2, 4'h3, 4'h4)));
        idle(1'b1);
        idle(1'b1);

        // Backpressure: first word held, next three nibbles still accepted.
        cycle(1'b1, 4'hA, 1'b0, 1'b0);
        cycle(1'b1, 4'hB, 1'b0, 1'b0);
        cycle(1'b1, 4'hC, 1'b0, 1'b0);
        cycle(1'b1, 4'hD, 1'b0, 1'b0);
        cycle(1'b1, 4'h5, 1'b0, 1'b0);
        cycle(1'b1, 4'h6, 1'b0, 1'b0);
        cycle(1'b1, 4'h7, 1'b0, 1'b0);
        check("held_word", 32'(bus.word_out), 32'(exp_word(4'hA, 4'hB, 4'hC, 4'hD)));
        cycle(1'b1, 4'h8, 1'b0, 1'b0);
        check("stall_nib_ready", 32'(bus.nib_ready), 32'd0);
        check("held_word_stable", 32'(bus.word_out), 32'(exp_word(4'hA, 4'hB, 4'hC, 4'hD)));
        cycle(1'b1, 4'h8, 1'b1, 1'b0);
        check("back_to_back_valid", 32'(bus.word_valid), 32'd1);
        check("back_to_back_word", 32'(bus.word_out), 32'(exp_word(4'h5, 4'h6, 4'h7, 4'h8)));
        idle(1'b1);
        idle(1'b1);

        // Streaming: eight nibbles back to back.
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i), 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // clr mid-word drops the nibble presented with it.
        cycle(1'b1, 4'hF, 1'b1, 1'b0);
        cycle(1'b1, 4'hE, 1'b1, 1'b0);
        cycle(1'b1, 4'h9, 1'b1, 1'b1);
        check("clr_sel_out", 32'(bus.sel_out), 32'(slot_of(0)));
        check("clr_word_valid", 32'(bus.word_valid), 32'd0);
        for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b1, 1'b0);
        check("post_clr_word", 32'(bus.word_out), 32'(exp_word(4'h1, 4'h2, 4'h3, 4'h4)));
        idle(1'b1);
        idle(1'b1);

        // Async reset while a word is held and the next one is part-filled.
        cycle(1'b1, 4'hA, 1'b0, 1'b0);
        cycle(1'b1, 4'hB, 1'b0, 1'b0);
        cycle(1'b1, 4'hC, 1'b0, 1'b0);
        cycle(1'b1, 4'hD, 1'b0, 1'b0);
        cycle(1'b1, 4'h1, 1'b0, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 1'b0);
        check("pre_rst_valid", 32'(bus.word_valid), 32'd1);
        check("pre_rst_sel", 32'(bus.sel_out), 32'(slot_of(2)));
        bus.nib_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_word_valid", 32'(bus.word_valid), 32'd0);
        check("async_rst_word_out", 32'(bus.word_out), 32'd0);
        check("async_rst_sel_out", 32'(bus.sel_out), 32'(slot_of(0)));
        check("async_rst_nib_ready", 32'(bus.nib_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        m_cnt = 0;
        @(negedge clk);
        for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Absolute time bound so a stuck run still terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
